// File: rtl/log_frame_packer.sv
// Packs 64 consecutive log-mel elements of one group into a wide frame word.
// Two banks alternate: one fills while the other waits on a valid/ready handshake.
module log_frame_packer #(
    parameter int O_BW   = 14,
    parameter int N_ELEM = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [O_BW-1:0]   data_i,
    input  logic [5:0]               in_group_idx,
    input  logic [6:0]               in_group_num,
    input  logic                     di_en,
    input  logic                     do_ready,
    output logic [O_BW*N_ELEM-1:0]   data_o,
    output logic [6:0]               out_group_num,
    output logic                     do_en,
    output logic                     seq_err,
    output logic                     ovf_err
);

    logic [1:0][N_ELEM-1:0][O_BW-1:0] bank_r;
    logic [1:0][6:0]                  bank_num_r;
    logic [1:0]                       full_r;
    logic                             fill_bank_r;
    logic                             rd_bank_r;
    logic [6:0]                       exp_idx_r;
    logic [6:0]                       cur_num_r;
    logic                             seq_err_r;
    logic                             ovf_err_r;

    logic                             wr_en_s;
    logic [5:0]                       wr_slot_s;
    logic                             complete_s;
    logic [6:0]                       exp_idx_s;
    logic [6:0]                       cur_num_s;
    logic                             seq_s;
    logic                             ovf_s;
    logic                             rd_fire_s;

    // Accept decision for the incoming element; full status is the pre-edge value.
    always_comb begin
        wr_en_s    = 1'b0;
        wr_slot_s  = 6'd0;
        complete_s = 1'b0;
        exp_idx_s  = exp_idx_r;
        cur_num_s  = cur_num_r;
        seq_s      = 1'b0;
        ovf_s      = 1'b0;
        if (di_en) begin
            if (full_r[fill_bank_r]) begin
                ovf_s = 1'b1;
            end else if (in_group_idx == 6'd0) begin
                wr_en_s   = 1'b1;
                wr_slot_s = 6'd0;
                cur_num_s = in_group_num;
                exp_idx_s = 7'd1;
                seq_s     = (exp_idx_r != 7'd0);
            end else if (({1'b0, in_group_idx} == exp_idx_r) && (in_group_num == cur_num_r)) begin
                wr_en_s   = 1'b1;
                wr_slot_s = in_group_idx;
                if (in_group_idx == 6'd63) begin
                    complete_s = 1'b1;
                    exp_idx_s  = 7'd0;
                end else begin
                    exp_idx_s  = exp_idx_r + 7'd1;
                end
            end else begin
                seq_s     = 1'b1;
                exp_idx_s = 7'd0;
            end
        end else begin
            exp_idx_s = exp_idx_r;
        end
    end

    assign rd_fire_s = full_r[rd_bank_r] & do_ready;

    // Control state: pointers, full flags, sequence tracking and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r      <= 2'b00;
            bank_num_r  <= '0;
            fill_bank_r <= 1'b0;
            rd_bank_r   <= 1'b0;
            exp_idx_r   <= 7'd0;
            cur_num_r   <= 7'd0;
            seq_err_r   <= 1'b0;
            ovf_err_r   <= 1'b0;
        end else begin
            exp_idx_r <= exp_idx_s;
            cur_num_r <= cur_num_s;
            seq_err_r <= seq_s;
            ovf_err_r <= ovf_s;
            // Completion and read-out never target the same bank on one edge.
            if (complete_s) begin
                full_r[fill_bank_r]     <= 1'b1;
                bank_num_r[fill_bank_r] <= cur_num_r;
                fill_bank_r             <= ~fill_bank_r;
            end else begin
                fill_bank_r <= fill_bank_r;
            end
            if (rd_fire_s) begin
                full_r[rd_bank_r] <= 1'b0;
                rd_bank_r         <= ~rd_bank_r;
            end else begin
                rd_bank_r <= rd_bank_r;
            end
        end
    end

    // Element storage for both banks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_r <= '0;
        end else if (wr_en_s) begin
            bank_r[fill_bank_r][wr_slot_s] <= data_i;
        end else begin
            bank_r <= bank_r;
        end
    end

    assign data_o        = bank_r[rd_bank_r];
    assign out_group_num = bank_num_r[rd_bank_r];
    assign do_en         = full_r[rd_bank_r];
    assign seq_err       = seq_err_r;
    assign ovf_err       = ovf_err_r;

endmodule

// File: tb/tb_log_frame_packer.sv
// Randomized self-checking bench for log_frame_packer against a frame-queue
// reference model built from the accept/completion/handshake rules.
module tb_log_frame_packer;

    localparam int O_BW = 14;
    localparam int W    = O_BW * 64;

    typedef struct packed {
        logic [6:0]   num;
        logic [W-1:0] data;
    } frame_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic signed [O_BW-1:0] data_i = '0;
    logic [5:0]             in_group_idx = '0;
    logic [6:0]             in_group_num = '0;
    logic                   di_en = 1'b0;
    logic                   do_ready = 1'b0;
    logic [W-1:0]           data_o;
    logic [6:0]             out_group_num;
    logic                   do_en;
    logic                   seq_err;
    logic                   ovf_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: completed frames pending delivery, plus the frame being assembled.
    frame_t                 q[$];
    logic [63:0][O_BW-1:0]  m_buf;
    int                     m_exp = 0;
    logic [6:0]             m_cur = 7'd0;
    logic                   e_seq = 1'b0;
    logic                   e_ovf = 1'b0;

    log_frame_packer #(.O_BW(O_BW), .N_ELEM(64)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .in_group_idx(in_group_idx),
        .in_group_num(in_group_num), .di_en(di_en), .do_ready(do_ready),
        .data_o(data_o), .out_group_num(out_group_num), .do_en(do_en),
        .seq_err(seq_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_exp = 0;
        m_cur = 7'd0;
        m_buf = '0;
        e_seq = 1'b0;
        e_ovf = 1'b0;
    endtask

    task automatic model_edge();
        bit both_full;
        bit pop;
        frame_t f;
        both_full = (q.size() == 2);
        pop       = (q.size() > 0) && do_ready;
        e_seq = 1'b0;
        e_ovf = 1'b0;
        if (pop) void'(q.pop_front());
        if (di_en) begin
            if (both_full) begin
                e_ovf = 1'b1;
            end else if (in_group_idx == 6'd0) begin
                if (m_exp != 0) e_seq = 1'b1;
                m_buf[0] = data_i;
                m_cur    = in_group_num;
                m_exp    = 1;
            end else if (int'(in_group_idx) == m_exp && in_group_num == m_cur) begin
                m_buf[in_group_idx] = data_i;
                if (in_group_idx == 6'd63) begin
                    f.num  = m_cur;
                    f.data = m_buf;
                    q.push_back(f);
                    m_exp = 0;
                end else begin
                    m_exp = m_exp + 1;
                end
            end else begin
                e_seq = 1'b1;
                m_exp = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check_val("do_en", W'(do_en), W'(q.size() > 0));
        check_val("seq_err", W'(seq_err), W'(e_seq));
        check_val("ovf_err", W'(ovf_err), W'(e_ovf));
        if (q.size() > 0) begin
            check_val("out_group_num", W'(out_group_num), W'(q[0].num));
            check_val("data_o", data_o, q[0].data);
        end
    endtask

    task automatic cyc(input logic di, input logic [5:0] idx, input logic [6:0] num,
                       input logic [O_BW-1:0] d, input logic rdy);
        di_en        = di;
        in_group_idx = idx;
        in_group_num = num;
        data_i       = d;
        do_ready     = rdy;
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 7'd0, '0, rdy);
    endtask

    // rmode: 0 hold ready low, 1 hold high, 2 random
    task automatic send_frame(input logic [6:0] num, input int first, input int last,
                              input int ofs, input int rmode);
        logic rdy;
        for (int i = first; i <= last; i++) begin
            rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
            cyc(1'b1, 6'(i), num, O_BW'(i * 3 + ofs), rdy);
        end
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_do_en", W'(do_en), W'(0));
        check_val("rst_data_o", data_o, W'(0));
        check_val("rst_group", W'(out_group_num), W'(0));
        check_val("rst_errs", W'({seq_err, ovf_err}), W'(0));
        model_reset();
        di_en    = 1'b0;
        do_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        int r_idx;
        logic [6:0] r_num;
        logic rdy_bias;
        model_reset();
        #12;
        check_val("reset_do_en", W'(do_en), W'(0));
        check_val("reset_data_o", data_o, W'(0));
        check_val("reset_group", W'(out_group_num), W'(0));
        check_val("reset_errs", W'({seq_err, ovf_err}), W'(0));
        rst = 1'b1;
        #1;

        // Single frame, data = 3*idx, consumed immediately.
        send_frame(7'd5, 0, 63, 0, 1);
        idle(3, 1'b1);

        // Two frames held, then released one at a time.
        send_frame(7'd7, 0, 63, $urandom, 0);
        send_frame(7'd8, 0, 63, $urandom, 0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Overflow with both banks full, then group 9 delivered after the remaining frame.
        send_frame(7'd10, 0, 63, $urandom, 0);
        send_frame(7'd11, 0, 63, $urandom, 0);
        cyc(1'b1, 6'd0, 7'd9, 14'h1234, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        send_frame(7'd9, 0, 63, $urandom, 0);
        idle(4, 1'b1);

        // Skipped index, then a clean frame.
        send_frame(7'd3, 0, 9, $urandom, 1);
        cyc(1'b1, 6'd11, 7'd3, 14'h0abc, 1'b1);
        send_frame(7'd4, 0, 63, $urandom, 1);
        idle(2, 1'b1);

        // Restart on idx 0, then a group mismatch mid-frame.
        send_frame(7'd2, 0, 29, $urandom, 1);
        send_frame(7'd6, 0, 63, $urandom, 1);
        idle(2, 1'b1);
        send_frame(7'd1, 0, 4, $urandom, 1);
        cyc(1'b1, 6'd5, 7'd7, 14'h3fff, 1'b1);
        send_frame(7'd1, 6, 8, $urandom, 1);
        idle(2, 1'b1);

        // Asynchronous reset with one bank full and a partial frame in flight.
        send_frame(7'd12, 0, 63, $urandom, 0);
        send_frame(7'd13, 0, 19, $urandom, 0);
        async_reset();
        send_frame(7'd14, 0, 63, $urandom, 0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Random traffic: mostly in-order elements with injected faults and bursty ready.
        r_idx    = 0;
        r_num    = 7'($urandom_range(0, 88));
        rdy_bias = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            int p;
            logic rdy;
            if (c % 300 == 0) rdy_bias = ~rdy_bias;
            rdy = rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            p = $urandom_range(0, 99);
            if (p < 10) begin
                cyc(1'b0, 6'($urandom), 7'($urandom), O_BW'($urandom), rdy);
            end else if (p < 13) begin
                cyc(1'b1, 6'($urandom), 7'($urandom_range(0, 88)), O_BW'($urandom), rdy);
            end else begin
                cyc(1'b1, 6'(r_idx), r_num, O_BW'($urandom), rdy);
                r_idx = (r_idx + 1) % 64;
                if (r_idx == 0) r_num = 7'($urandom_range(0, 88));
            end
        end
        idle(8, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
